// File: rtl/awgn_pkg.sv
// Shared constants, types and helpers for the AWGN range-reduction datapath.
package awgn_pkg;

    localparam int AWGN_U_WIDTH  = 48;
    localparam int AWGN_SH_WIDTH = 6;

    // Per-word shift source: external amount or leading-zero count.
    typedef enum logic {
        SHIFT_EXT  = 1'b0,
        SHIFT_AUTO = 1'b1
    } shift_mode_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/awgn_lzc.sv
// Combinational leading-zero counter. An all-zero word returns WIDTH.
module awgn_lzc
    import awgn_pkg::*;
#(
    parameter int WIDTH = AWGN_U_WIDTH,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [CW-1:0]    count_out
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count_out = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_in[i]) begin
                count_out = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/u0_normalizer.sv
// Three-stage pipelined left shifter / normaliser with a global-stall
// valid/ready handshake. S1 captures the word and the clamped shift amount,
// S2 applies the upper (coarse) shift levels, S3 the lower (fine) levels.
module u0_normalizer
    import awgn_pkg::*;
#(
    parameter int WIDTH = AWGN_U_WIDTH,
    parameter int SHW   = AWGN_SH_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] u_in,
    input  logic [SHW-1:0]   shamt_in,
    input  logic             mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [SHW-1:0]   exp_out,
    output logic             zero_out
);

    // Coarse levels are the upper ceil(SHW/2) shift bits, fine the rest.
    localparam int NC  = (SHW + 1) / 2;
    localparam int NF  = SHW - NC;
    localparam int LZW = clog2(WIDTH + 1);
    localparam logic [SHW-1:0] SH_SAT = SHW'(WIDTH);

    // The shift field must be able to hold WIDTH itself (the saturated value).
    generate
        if (WIDTH < 2 || (2 ** SHW) <= WIDTH) begin : g_param_check
            $error("u0_normalizer: need WIDTH >= 2 and 2**SHW > WIDTH");
        end
    endgenerate

    // Pipeline state
    logic             v1_q,  v1_d;
    logic [WIDTH-1:0] u1_q,  u1_d;
    logic [SHW-1:0]   sh1_q, sh1_d;
    logic             v2_q,  v2_d;
    logic [WIDTH-1:0] u2_q,  u2_d;
    logic [SHW-1:0]   sh2_q, sh2_d;
    logic             v3_q,  v3_d;
    logic [WIDTH-1:0] x3_q,  x3_d;
    logic [SHW-1:0]   e3_q,  e3_d;
    logic             z3_q,  z3_d;

    logic             adv;
    logic [LZW-1:0]   lzc_cnt;
    logic [SHW-1:0]   sh_eff;
    logic [WIDTH-1:0] coarse_res;
    logic [WIDTH-1:0] fine_res;
    shift_mode_t      mode_sel;

    // Global stall: every stage moves together whenever the output slot frees.
    assign adv      = ~v3_q | out_ready;
    assign in_ready = adv & ~reset;
    assign mode_sel = shift_mode_t'(mode_in);

    awgn_lzc #(
        .WIDTH (WIDTH),
        .CW    (LZW)
    ) u_lzc (
        .data_in   (u_in),
        .count_out (lzc_cnt)
    );

    // Effective shift amount; external amounts clamp to WIDTH rather than wrap.
    always_comb begin
        sh_eff = shamt_in;
        if (mode_sel == SHIFT_AUTO) begin
            sh_eff = SHW'(lzc_cnt);
        end else if (shamt_in > SH_SAT) begin
            sh_eff = SH_SAT;
        end
    end

    // Coarse levels (MSB shift bits first), chained through per-level blocks.
    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_coarse
            logic [WIDTH-1:0] lvl_in;
            logic [WIDTH-1:0] lvl;
            if (gi == 0) begin : g_first
                assign lvl_in = u1_q;
            end else begin : g_next
                assign lvl_in = g_coarse[gi-1].lvl;
            end
            assign lvl = sh1_q[SHW-1-gi] ? (lvl_in << (2 ** (SHW - 1 - gi))) : lvl_in;
        end
        assign coarse_res = g_coarse[NC-1].lvl;

        for (gi = 0; gi < NF; gi++) begin : g_fine
            logic [WIDTH-1:0] lvl_in;
            logic [WIDTH-1:0] lvl;
            if (gi == 0) begin : g_first
                assign lvl_in = u2_q;
            end else begin : g_next
                assign lvl_in = g_fine[gi-1].lvl;
            end
            assign lvl = sh2_q[NF-1-gi] ? (lvl_in << (2 ** (NF - 1 - gi))) : lvl_in;
        end
        assign fine_res = g_fine[NF-1].lvl;
    endgenerate

    // Next-state for all stages: hold on stall, advance (bubbles included) otherwise.
    always_comb begin
        v1_d  = v1_q;
        u1_d  = u1_q;
        sh1_d = sh1_q;
        v2_d  = v2_q;
        u2_d  = u2_q;
        sh2_d = sh2_q;
        v3_d  = v3_q;
        x3_d  = x3_q;
        e3_d  = e3_q;
        z3_d  = z3_q;
        if (adv) begin
            v1_d  = in_valid & in_ready;
            u1_d  = u_in;
            sh1_d = sh_eff;
            v2_d  = v1_q;
            u2_d  = coarse_res;
            sh2_d = sh1_q;
            v3_d  = v2_q;
            x3_d  = fine_res;
            e3_d  = sh2_q;
            z3_d  = (fine_res == '0);
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            u1_q  <= '0;
            sh1_q <= '0;
            v2_q  <= 1'b0;
            u2_q  <= '0;
            sh2_q <= '0;
            v3_q  <= 1'b0;
            x3_q  <= '0;
            e3_q  <= '0;
            z3_q  <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            u1_q  <= u1_d;
            sh1_q <= sh1_d;
            v2_q  <= v2_d;
            u2_q  <= u2_d;
            sh2_q <= sh2_d;
            v3_q  <= v3_d;
            x3_q  <= x3_d;
            e3_q  <= e3_d;
            z3_q  <= z3_d;
        end
    end

    assign out_valid = v3_q;
    assign x_out     = x3_q;
    assign exp_out   = e3_q;
    assign zero_out  = z3_q;

endmodule

// File: tb/tb_u0_normalizer.sv
// Directed and randomised checks for u0_normalizer (WIDTH=48, SHW=6).
module tb_u0_normalizer;
    import awgn_pkg::*;

    localparam int W = 48;
    localparam int S = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] u_in;
    logic [S-1:0] shamt_in;
    logic         mode_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x_out;
    logic [S-1:0] exp_out;
    logic         zero_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [S-1:0] e;
        logic         z;
    } exp_t;

    always #5 clk = ~clk;

    u0_normalizer #(.WIDTH(W), .SHW(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u_in      (u_in),
        .shamt_in  (shamt_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .exp_out   (exp_out),
        .zero_out  (zero_out)
    );

    // Reference: plain shift by LZC or clamped external amount.
    function automatic exp_t model(input logic [W-1:0] u, input logic [S-1:0] sa, input logic m);
        exp_t r;
        int   sh;
        if (m) begin
            sh = 0;
            while (sh < W && !u[W-1-sh]) sh++;
        end else begin
            sh = (int'(sa) > W) ? W : int'(sa);
        end
        r.x = (sh >= W) ? '0 : (u << sh);
        r.e = S'(sh);
        r.z = (r.x == '0);
        return r;
    endfunction

    // Send one word into an empty pipeline and wait (bounded) for its result.
    task automatic run_one(input logic [W-1:0] u, input logic [S-1:0] sa, input logic m,
                           output exp_t got, output int lat, output bit ok);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        u_in      = u;
        shamt_in  = sa;
        mode_in   = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20 && !out_valid) begin
            @(posedge clk); #1;
            lat++;
        end
        ok    = out_valid;
        got.x = x_out;
        got.e = exp_out;
        got.z = zero_out;
        @(posedge clk); #1;
    endtask

    // Stream n words; rmode 0 = always ready, 1 = ready dropped 4 cycles, 2 = random ready.
    task automatic stream(input int n, input int rmode, input bit rnd,
                          output int got, output int span, output int stall_cycles);
        exp_t         q[$];
        exp_t         e;
        int           sent = 0;
        int           cyc = 0;
        int           first = -1;
        int           last = -1;
        bit           prev_hold = 0;
        bit           in_fire;
        logic [W-1:0] px;
        logic [S-1:0] pe;
        logic         pz;
        logic [63:0]  r;
        got = 0;
        stall_cycles = 0;
        while (got < n && cyc < n * 8 + 100) begin
            if (!in_valid && sent < n) begin
                if (rnd) begin
                    r        = {$urandom(), $urandom()};
                    u_in     = r[W-1:0] >> $urandom_range(0, W);
                    mode_in  = 1'($urandom_range(0, 1));
                    shamt_in = S'($urandom_range(0, 63));
                end else begin
                    u_in     = 48'h0000_0000_000F;
                    mode_in  = 1'b0;
                    shamt_in = S'(sent);
                end
                in_valid = 1'b1;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= 8 && cyc < 12);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_flow cyc=%0d got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (!in_ready) stall_cycles++;
            if (prev_hold) begin
                checks++;
                if (x_out !== px || exp_out !== pe || zero_out !== pz || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got %h/%0d/%b want %h/%0d/%b", cyc, x_out, exp_out, zero_out, px, pe, pz);
                end
            end
            in_fire = in_valid && in_ready;
            if (in_fire) q.push_back(model(u_in, shamt_in, mode_in));
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra cyc=%0d got x=%h with nothing expected", cyc, x_out);
                end else begin
                    e = q.pop_front();
                    if (x_out !== e.x || exp_out !== e.e || zero_out !== e.z) begin
                        errors++;
                        $display("FAIL stream_word %0d got %h/%0d/%b want %h/%0d/%b", got, x_out, exp_out, zero_out, e.x, e.e, e.z);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            prev_hold = out_valid && !out_ready;
            px = x_out;
            pe = exp_out;
            pz = zero_out;
            @(posedge clk); #1;
            cyc++;
            if (in_fire) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        span = last - first;
        checks++;
        if (got !== n) begin
            errors++;
            $display("FAIL stream_count got %0d want %0d", got, n);
        end
        $display("stream n=%0d rmode=%0d received=%0d cycles=%0d", n, rmode, got, cyc);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        u_in      = '0;
        shamt_in  = '0;
        mode_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || x_out !== '0 || exp_out !== '0 || zero_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b x=%h e=%0d z=%b want 0/0/0/0/0", in_ready, out_valid, x_out, exp_out, zero_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", in_ready);
        end
        $display("reset: rdy=%b vld=%b", in_ready, out_valid);
        @(posedge clk); #1;
    endtask

    // Directed vector table shared by the single-word tests.
    task automatic check_vec(input string name, input logic [W-1:0] u, input logic [S-1:0] sa,
                             input logic m, input logic [W-1:0] ex, input logic [S-1:0] ee, input logic ez);
        exp_t got;
        int   lat;
        bit   ok;
        run_one(u, sa, m, got, lat, ok);
        $display("%s u=%h sh=%0d mode=%b -> x=%h exp=%0d zero=%b lat=%0d", name, u, sa, m, got.x, got.e, got.z, lat);
        checks++;
        if (!ok || lat !== 3) begin
            errors++;
            $display("FAIL %s_latency got %0d (valid=%b) want 3", name, lat, ok);
        end
        checks++;
        if (got.x !== ex || got.e !== ee || got.z !== ez) begin
            errors++;
            $display("FAIL %s got %h/%0d/%b want %h/%0d/%b", name, got.x, got.e, got.z, ex, ee, ez);
        end
    endtask

    task automatic test_auto();
        check_vec("auto_bit16", 48'h0000_0001_0000, 6'd0, 1'b1, 48'h8000_0000_0000, 6'd31, 1'b0);
        check_vec("auto_msb",   48'h8000_0000_0000, 6'd9, 1'b1, 48'h8000_0000_0000, 6'd0,  1'b0);
        check_vec("auto_lsb",   48'h0000_0000_0001, 6'd0, 1'b1, 48'h8000_0000_0000, 6'd47, 1'b0);
        check_vec("auto_mix",   48'h0000_0ABC_0000, 6'd0, 1'b1, 48'hABC0_0000_0000, 6'd20, 1'b0);
    endtask

    task automatic test_external();
        check_vec("ext_47", 48'hFFFF_FFFF_FFFF, 6'd47, 1'b0, 48'h8000_0000_0000, 6'd47, 1'b0);
        check_vec("ext_48", 48'hFFFF_FFFF_FFFF, 6'd48, 1'b0, 48'h0000_0000_0000, 6'd48, 1'b1);
        check_vec("ext_63", 48'hFFFF_FFFF_FFFF, 6'd63, 1'b0, 48'h0000_0000_0000, 6'd48, 1'b1);
        check_vec("ext_4",  48'h0123_4567_89AB, 6'd4,  1'b0, 48'h1234_5678_9AB0, 6'd4,  1'b0);
        check_vec("ext_0",  48'h0123_4567_89AB, 6'd0,  1'b0, 48'h0123_4567_89AB, 6'd0,  1'b0);
        check_vec("ext_33", 48'h0000_0000_8001, 6'd33, 1'b0, 48'h0002_0000_0000, 6'd33, 1'b0);
    endtask

    task automatic test_zero();
        check_vec("zero_auto", 48'h0, 6'd0, 1'b1, 48'h0, 6'd48, 1'b1);
        check_vec("zero_ext",  48'h0, 6'd5, 1'b0, 48'h0, 6'd5,  1'b1);
    endtask

    task automatic test_back_to_back();
        int got;
        int span;
        int stalls;
        stream(10, 0, 1'b0, got, span, stalls);
        checks++;
        if (span !== 9 || stalls !== 0) begin
            errors++;
            $display("FAIL b2b_throughput got span=%0d stalls=%0d want span=9 stalls=0", span, stalls);
        end
        stream(10, 1, 1'b0, got, span, stalls);
        checks++;
        if (stalls !== 4) begin
            errors++;
            $display("FAIL backpressure_stalls got %0d want 4", stalls);
        end
    endtask

    task automatic test_reset_mid();
        exp_t got;
        int   lat;
        bit   ok;
        int   stray = 0;
        out_ready = 1'b0;
        mode_in   = 1'b0;
        shamt_in  = 6'd1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            u_in     = 48'h0000_0000_0100 + W'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight got out_valid=%b want 1", out_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_in_reset got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || x_out !== '0) begin
            errors++;
            $display("FAIL mid_flush got vld=%b x=%h want 0/0", out_valid, x_out);
        end
        run_one(48'h0000_0000_0003, 6'd2, 1'b0, got, lat, ok);
        $display("reset_mid new word -> x=%h exp=%0d lat=%0d", got.x, got.e, lat);
        checks++;
        if (!ok || lat !== 3 || got.x !== 48'h0000_0000_000C || got.e !== 6'd2) begin
            errors++;
            $display("FAIL mid_new_word got x=%h e=%0d lat=%0d want x=c e=2 lat=3", got.x, got.e, lat);
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stray++;
            @(posedge clk); #1;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL mid_stale_words got %0d stray outputs want 0", stray);
        end
    endtask

    task automatic test_random();
        int got;
        int span;
        int stalls;
        stream(2000, 2, 1'b1, got, span, stalls);
    endtask

    initial begin
        test_reset();
        test_auto();
        test_external();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
